// File: rtl/riscv_ctrl_pkg.sv
// Shared types for the multicycle RISC-V controller: opcodes, FSM states,
// instruction classes and ALUOp encodings.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_SD  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

   typedef enum logic [2:0] {CLS_R, CLS_LD, CLS_SD, CLS_BEQ, CLS_ILLEGAL} op_class_t;

   function automatic op_class_t decode_class(input logic [6:0] op);
      op_class_t cls;
      case (op)
         OP_R:    cls = CLS_R;
         OP_LD:   cls = CLS_LD;
         OP_SD:   cls = CLS_SD;
         OP_BEQ:  cls = CLS_BEQ;
         default: cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Memory wait counter: counts stalled request cycles and flags a timeout when
// the count has reached MAX_WAIT and ready is still low.
module mem_wait_timer #(
   parameter int MAX_WAIT = 15,
   parameter int WAIT_W   = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic req,
   input  logic ready,
   output logic timeout
);

   logic [WAIT_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         count_reg <= '0;
      end else if (req && !ready) begin
         count_reg <= count_reg + WAIT_W'(1);
      end
   end

   // A ready in the limit cycle still completes the access.
   assign timeout = req && !ready && (count_reg == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer for the R/LD/SD/BEQ datapath with req/ready memories.
// Optional ILLEGAL_OP_TRAP_EN adds a sticky TRAP state and the trap output.
module multicycle_control
   import riscv_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 15,
   parameter int WAIT_W   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic [6:0] OpCode,
   input  logic       imem_ready,
   input  logic       dmem_ready,
   output logic       imem_req,
   output logic       dmem_req,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       Branch,
   output logic       ALUSrc,
   output logic [1:0] ALUOp,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       instr_done,
   output logic       mem_err
`ifdef ILLEGAL_OP_TRAP_EN
   ,
   output logic       trap
`endif
);

`ifdef ILLEGAL_OP_TRAP_EN
   localparam state_t FAULT_STATE = TRAP;
`else
   localparam state_t FAULT_STATE = FETCH;
`endif

   state_t    state_reg, state_next;
   op_class_t class_reg, class_next;
   op_class_t dec_class;
   logic      fetch_active_reg, fetch_active_next;

   logic       imem_req_raw, dmem_req_raw, mem_ready, timeout, timer_clear;
   logic       irw_raw, pcw_raw, br_raw, asrc_raw, mrd_raw, mwr_raw;
   logic       mtr_raw, rw_raw, done_raw, err_raw;
   logic [1:0] aluop_raw;

   assign dec_class = decode_class(OpCode);

   // A fetch that has started keeps requesting even after run falls.
   assign imem_req_raw = (state_reg == FETCH) && (run || fetch_active_reg);
   assign dmem_req_raw = (state_reg == MEM);
   assign mem_ready    = (state_reg == MEM) ? dmem_ready : imem_ready;
   assign timer_clear  = (state_next != state_reg) || err_raw;

   mem_wait_timer #(
      .MAX_WAIT (MAX_WAIT),
      .WAIT_W   (WAIT_W)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (timer_clear),
      .req     (imem_req_raw || dmem_req_raw),
      .ready   (mem_ready),
      .timeout (timeout)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg        <= FETCH;
         class_reg        <= CLS_R;
         fetch_active_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         class_reg        <= class_next;
         fetch_active_reg <= fetch_active_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      class_next        = class_reg;
      fetch_active_next = fetch_active_reg;
      irw_raw   = 1'b0;
      pcw_raw   = 1'b0;
      br_raw    = 1'b0;
      asrc_raw  = 1'b0;
      aluop_raw = ALUOP_ADD;
      mrd_raw   = 1'b0;
      mwr_raw   = 1'b0;
      mtr_raw   = 1'b0;
      rw_raw    = 1'b0;
      done_raw  = 1'b0;
      err_raw   = 1'b0;
      case (state_reg)
         FETCH: begin
            if (imem_req_raw) begin
               if (imem_ready) begin
                  irw_raw           = 1'b1;
                  pcw_raw           = 1'b1;
                  fetch_active_next = 1'b0;
                  state_next        = DECODE;
               end else if (timeout) begin
                  err_raw           = 1'b1;
                  fetch_active_next = 1'b0;
                  state_next        = FAULT_STATE;
               end else begin
                  fetch_active_next = 1'b1;
               end
            end
         end
         DECODE: begin
            class_next = dec_class;
            if (dec_class == CLS_ILLEGAL) begin
`ifndef ILLEGAL_OP_TRAP_EN
               done_raw = 1'b1;
`endif
               state_next = FAULT_STATE;
            end else begin
               state_next = EXEC;
            end
         end
         EXEC: begin
            case (class_reg)
               CLS_R: begin
                  aluop_raw  = ALUOP_FUNCT;
                  state_next = WB;
               end
               CLS_LD, CLS_SD: begin
                  asrc_raw   = 1'b1;
                  state_next = MEM;
               end
               CLS_BEQ: begin
                  aluop_raw  = ALUOP_SUB;
                  br_raw     = 1'b1;
                  done_raw   = 1'b1;
                  state_next = FETCH;
               end
               default: state_next = FETCH;
            endcase
         end
         MEM: begin
            asrc_raw = 1'b1;
            mrd_raw  = (class_reg == CLS_LD);
            mwr_raw  = (class_reg == CLS_SD);
            if (dmem_ready) begin
               if (class_reg == CLS_LD) begin
                  state_next = WB;
               end else begin
                  done_raw   = 1'b1;
                  state_next = FETCH;
               end
            end else if (timeout) begin
               err_raw    = 1'b1;
               state_next = FAULT_STATE;
            end
         end
         WB: begin
            rw_raw     = 1'b1;
            mtr_raw    = (class_reg == CLS_LD);
            done_raw   = 1'b1;
            state_next = FETCH;
         end
         default: state_next = FAULT_STATE;
      endcase
   end

   // Reset forces every output low, including mid-instruction requests.
   assign imem_req   = rst_n && imem_req_raw;
   assign dmem_req   = rst_n && dmem_req_raw;
   assign IRWrite    = rst_n && irw_raw;
   assign PCWrite    = rst_n && pcw_raw;
   assign Branch     = rst_n && br_raw;
   assign ALUSrc     = rst_n && asrc_raw;
   assign ALUOp      = rst_n ? aluop_raw : 2'b00;
   assign MemRead    = rst_n && mrd_raw;
   assign MemWrite   = rst_n && mwr_raw;
   assign MemtoReg   = rst_n && mtr_raw;
   assign RegWrite   = rst_n && rw_raw;
   assign instr_done = rst_n && done_raw;
   assign mem_err    = rst_n && err_raw;
`ifdef ILLEGAL_OP_TRAP_EN
   assign trap       = rst_n && (state_reg == TRAP);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed programs push expected
// retire/error events and per-cycle probes; a negedge monitor checks them.
`timescale 1ns/1ps
module tb_multicycle_control;
   import riscv_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic       imem_ready = 1'b0;
   logic       dmem_ready = 1'b0;
   logic [6:0] OpCode = 7'b0;
   logic       imem_req, dmem_req, IRWrite, PCWrite, Branch, ALUSrc;
   logic [1:0] ALUOp;
   logic       MemRead, MemWrite, MemtoReg, RegWrite, instr_done, mem_err;
   logic       trap_sig;

   always #5 clk = ~clk;

`ifdef ILLEGAL_OP_TRAP_EN
   logic trap;
   assign trap_sig = trap;
`else
   assign trap_sig = 1'b0;
`endif

   multicycle_control dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .run        (run),
      .OpCode     (OpCode),
      .imem_ready (imem_ready),
      .dmem_ready (dmem_ready),
      .imem_req   (imem_req),
      .dmem_req   (dmem_req),
      .IRWrite    (IRWrite),
      .PCWrite    (PCWrite),
      .Branch     (Branch),
      .ALUSrc     (ALUSrc),
      .ALUOp      (ALUOp),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .MemtoReg   (MemtoReg),
      .RegWrite   (RegWrite),
      .instr_done (instr_done),
      .mem_err    (mem_err)
`ifdef ILLEGAL_OP_TRAP_EN
      ,
      .trap       (trap)
`endif
   );

   localparam logic [15:0] V_IREQ = 16'h4000, V_DREQ = 16'h2000, V_IRW = 16'h1000;
   localparam logic [15:0] V_PCW  = 16'h0800, V_BR   = 16'h0400, V_ASRC = 16'h0200;
   localparam logic [15:0] V_AFN  = 16'h0100, V_ASUB = 16'h0080, V_MRD  = 16'h0040;
   localparam logic [15:0] V_MWR  = 16'h0020, V_MTR  = 16'h0010, V_RW   = 16'h0008;
   localparam logic [15:0] V_DONE = 16'h0004, V_ERR  = 16'h0002, V_TRAP = 16'h0001;
   localparam logic [15:0] V_ALL  = 16'h7FFF;

   wire [15:0] obs = {1'b0, imem_req, dmem_req, IRWrite, PCWrite, Branch, ALUSrc, ALUOp,
                      MemRead, MemWrite, MemtoReg, RegWrite, instr_done, mem_err, trap_sig};

   typedef struct {
      int          cyc;
      string       name;
      logic [15:0] mask;
      logic [15:0] value;
   } exp_t;

   exp_t evt_q[$];
   exp_t probe_q[$];

   int   cyc = 0;
   int   mark = 0;
   int   stim_timeouts = 0;
   logic finish_req = 1'b0;
   int   n_tests = 0;
   int   n_fails = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: probes fire at their cycle, events fire on instr_done/mem_err.
   always @(negedge clk) begin
      exp_t e;
      while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
         e = probe_q.pop_front();
         n_tests++;
         if (e.cyc < cyc) begin
            n_fails++;
            $display("FAIL %s: probe for cycle %0d not reached (now %0d)", e.name, e.cyc, cyc);
         end else if ((obs & e.mask) !== e.value) begin
            n_fails++;
            $display("FAIL %s: cycle %0d outputs %h, expected %h (mask %h)",
                     e.name, cyc, obs & e.mask, e.value, e.mask);
         end
      end
      if (rst_n && (instr_done || mem_err)) begin
         n_tests++;
         if (evt_q.size() == 0) begin
            n_fails++;
            $display("FAIL unexpected_event: cycle %0d outputs %h, expected no event", cyc, obs);
         end else begin
            e = evt_q.pop_front();
            if (e.cyc != cyc || (obs & e.mask) !== e.value) begin
               n_fails++;
               $display("FAIL %s: cycle %0d outputs %h, expected cycle %0d outputs %h (mask %h)",
                        e.name, cyc, obs & e.mask, e.cyc, e.value, e.mask);
            end
         end
      end
      if (finish_req) begin
         n_tests++;
         if (evt_q.size() != 0) begin
            n_fails++;
            $display("FAIL events_pending: %0d left, expected 0 (next %s)", evt_q.size(), evt_q[0].name);
         end
         n_tests++;
         if (probe_q.size() != 0) begin
            n_fails++;
            $display("FAIL probes_pending: %0d left, expected 0", probe_q.size());
         end
         n_tests++;
         if (stim_timeouts != 0) begin
            n_fails++;
            $display("FAIL fetch_wait: %0d fetches never saw IRWrite, expected 0", stim_timeouts);
         end
         $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
         $finish;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Cycle k of a test is the k-th cycle after reset release (k=1 is the first FETCH).
   task automatic wait_cycle(input int k);
      while (cyc < mark + k - 1) next_cycle();
   endtask

   task automatic push_probe(input int k, input string name, input logic [15:0] mask,
                             input logic [15:0] value);
      exp_t e;
      e.cyc = mark + k - 1; e.name = name; e.mask = mask; e.value = value;
      probe_q.push_back(e);
   endtask

   task automatic push_evt(input int k, input string name, input logic [15:0] mask,
                           input logic [15:0] value);
      exp_t e;
      e.cyc = mark + k - 1; e.name = name; e.mask = mask; e.value = value;
      evt_q.push_back(e);
   endtask

   task automatic do_reset(input logic r, input logic ir, input logic dr);
      exp_t e;
      next_cycle();
      rst_n = 1'b0;
      run = r; imem_ready = ir; dmem_ready = dr;
      e.cyc = cyc; e.name = "reset_outputs"; e.mask = V_ALL; e.value = 16'h0;
      probe_q.push_back(e);
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      mark = cyc;
      #1;
   endtask

   // Waits for the fetch ready cycle and presents the instruction word to DECODE.
   task automatic fetch(input logic [6:0] op);
      int n = 0;
      while (!IRWrite && n < 40) begin
         next_cycle();
         n++;
      end
      if (!IRWrite) stim_timeouts++;
      else OpCode = op;
      next_cycle();
   endtask

   initial begin
      // Back-to-back R, LD, SD, BEQ with both memories always ready.
      do_reset(1'b1, 1'b1, 1'b1);
      push_evt(4,  "r_retire",   V_ALL, V_RW | V_DONE);
      push_evt(9,  "ld_retire",  V_ALL, V_RW | V_MTR | V_DONE);
      push_evt(13, "sd_retire",  V_ALL, V_DREQ | V_ASRC | V_MWR | V_DONE);
      push_evt(16, "beq_retire", V_ALL, V_BR | V_ASUB | V_DONE);
      fetch(OP_R);
      fetch(OP_LD);
      fetch(OP_SD);
      fetch(OP_BEQ);
      run = 1'b0;
      wait_cycle(20);

      // LD whose data access waits: dmem_ready arrives in the third MEM cycle.
      do_reset(1'b1, 1'b1, 1'b0);
      push_probe(1, "ld_fetch", V_IREQ | V_IRW | V_PCW, V_IREQ | V_IRW | V_PCW);
      for (int k = 4; k <= 6; k++)
         push_probe(k, "ld_mem_wait", V_DREQ | V_MRD | V_MWR | V_RW, V_DREQ | V_MRD);
      push_evt(7, "ld_late_retire", V_ALL, V_RW | V_MTR | V_DONE);
      fetch(OP_LD);
      run = 1'b0;
      wait_cycle(6);
      dmem_ready = 1'b1;
      wait_cycle(10);

      // LD with dmem_ready never asserted: timeout after 15 waiting cycles.
      do_reset(1'b1, 1'b1, 1'b0);
      push_evt(19, "ld_timeout", V_ALL & ~(V_DREQ | V_MRD), V_ASRC | V_ERR);
`ifdef ILLEGAL_OP_TRAP_EN
      push_probe(20, "timeout_trap", V_TRAP | V_DREQ | V_RW, V_TRAP);
`else
      push_probe(20, "timeout_req_drop", V_DREQ | V_IREQ | V_RW, 16'h0);
`endif
      for (int k = 21; k <= 24; k++)
         push_probe(k, "timeout_no_regwrite", V_RW | V_DONE, 16'h0);
      fetch(OP_LD);
      run = 1'b0;
      wait_cycle(26);

      // Illegal opcode (OP-IMM is not supported).
      do_reset(1'b1, 1'b1, 1'b1);
`ifdef ILLEGAL_OP_TRAP_EN
      for (int k = 3; k <= 8; k++)
         push_probe(k, "illegal_trap", V_TRAP | V_IREQ | V_RW | V_MWR | V_DONE, V_TRAP);
      fetch(7'b0010011);
`else
      push_evt(2, "illegal_nop", V_ALL, V_DONE);
      for (int k = 3; k <= 8; k++)
         push_probe(k, "illegal_no_write", V_RW | V_MWR | V_DONE, 16'h0);
      fetch(7'b0010011);
      run = 1'b0;
`endif
      wait_cycle(10);

      // Reset asserted while an SD is waiting in MEM.
      do_reset(1'b1, 1'b1, 1'b0);
      push_probe(4, "sd_mem_req", V_DREQ | V_MWR | V_MRD, V_DREQ | V_MWR);
      push_probe(6, "reset_drops_dreq", V_DREQ | V_MWR, 16'h0);
      push_probe(7, "fetch_restart", V_IREQ | V_DREQ, V_IREQ);
      fetch(OP_SD);
      run = 1'b0;
      wait_cycle(5);
      rst_n = 1'b0;
      wait_cycle(7);
      run = 1'b1;
      imem_ready = 1'b0;
      rst_n = 1'b1;

      // run low holds FETCH without requesting; raising run starts the fetch.
      do_reset(1'b0, 1'b1, 1'b1);
      for (int k = 1; k <= 5; k++)
         push_probe(k, "run_low_idle", V_IREQ | V_IRW, 16'h0);
      push_probe(6, "run_high_req", V_IREQ, V_IREQ);
      wait_cycle(6);
      imem_ready = 1'b0;
      run = 1'b1;
      next_cycle();
      finish_req = 1'b1;
   end

endmodule
